ll_walk_resp: RTL
=================

Name: ll_walk_resp

Overview:
- Responder end of the linked-list pointer request interface.
- Accepts pointer strobes (ptr + ptr_vld, no backpressure) from the request generator and buffers them in a small FIFO.
- For each buffered pointer, walks an internal next-pointer table from that node until the NIL terminator, one hop per cycle.
- Returns head, tail, list length and an error flag as a one-cycle result strobe; results drive display/LED logic in the board wrapper.

Parameters:
- PTR_W, 4, pointer width. NIL = all-ones (4'hF). Node table holds entries 0 .. 2^PTR_W-2.
- FIFO_DEPTH, 4, request FIFO entries (power of two, >= 2).
- MAX_HOPS, 2^PTR_W-1 (15), hop limit. A walk reaching it is declared cyclic.

Ports:
- clk  in  1  single clock (slow_clk domain in the wrapper)
- rst  in  1  synchronous reset, active-high
- in_ptr  in  PTR_W  requested head pointer
- in_ptr_vld  in  1  one-cycle request strobe; sampled every clk
- wr_en  in  1  table write strobe
- wr_addr  in  PTR_W  table entry to write; writes to NIL are ignored
- wr_next  in  PTR_W  new next-pointer value
- out_head  out  PTR_W  head pointer of the completed request
- out_tail  out  PTR_W  last node visited (NIL for a NIL request)
- out_len  out  PTR_W  nodes visited
- out_err  out  1  hop limit hit (cycle detected)
- out_vld  out  1  one-cycle result strobe
- busy  out  1  engine not IDLE, or FIFO non-empty
- ovf  out  1  sticky: a request was dropped because the FIFO was full

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO emptied; FSM goes to IDLE.
  - All outputs 0, except out_tail = NIL.
  - ovf cleared.
  - Table initialised to next[i]=i+1 for i < 2^PTR_W-2, and next[2^PTR_W-2]=NIL (default chain 0->1->...->14->NIL).
  - rst during a walk aborts it with no out_vld; all queued requests are lost.
- FIFO:
  - Push when in_ptr_vld=1 and (not full, or a pop occurs in the same cycle).
  - Otherwise the request is dropped and ovf is set to 1.
  - Simultaneous push and pop when empty: entry still passes through the FIFO; no bypass.
- Table:
  - Asynchronous read, synchronous write.
  - A write in cycle t is visible to walk reads from cycle t+1; reads in cycle t see the old value.
- FSM states IDLE, WALK, DONE:
  - IDLE, FIFO non-empty: pop the FIFO; head <= ptr; cur <= ptr; len <= 0.
    - If ptr==NIL, go to DONE with tail=NIL, len=0, err=0.
    - Otherwise go to WALK.
  - IDLE, FIFO empty: stay in IDLE.
  - WALK, each cycle: len <= len+1.
    - If next[cur]==NIL: tail <= cur; go to DONE.
    - Else if len+1 == MAX_HOPS: tail <= cur; err <= 1; go to DONE.
    - Else: cur <= next[cur].
  - DONE: out_* registers hold the result and out_vld=1 for exactly one cycle; go to IDLE.
  - out_* values hold between strobes.
- Latency (FIFO empty, engine idle, strobe in cycle 0):
  - NIL request: out_vld in cycle 2.
  - L-node list: out_vld in cycle L+2.
  - Cyclic list: out_vld in cycle MAX_HOPS+2.
- Back-to-back throughput: one request per (L+2) cycles, since DONE costs one cycle.
- Arithmetic:
  - len saturates at MAX_HOPS and never wraps.
  - A pointer with value NIL is never dereferenced.

Optional Feature:
- Macro: LL_WALK_SUM_EN.
- When defined:
  - Adds output out_sum (2*PTR_W bits): unsigned sum of the indices of all visited nodes, valid with out_vld.
  - 0 for a NIL request.
  - Reset value 0.
- When undefined: the port and its accumulator do not exist; all other behaviour is identical.

Test Plan:
- Reset, then strobe in_ptr=12 in cycle 0 -> out_vld in cycle 5; head=12, tail=14, len=3, err=0 (sum=39 with LL_WALK_SUM_EN).
- Strobe in_ptr=15 (NIL) -> out_vld in cycle 2; head=15, tail=15, len=0, err=0.
- Write next[14]=3, then strobe in_ptr=0 -> out_vld after 15 WALK cycles; err=1, len=15, tail=14.
- 6 strobes on consecutive cycles (ptrs 0,1,2,3,4,5) with default table:
  - -> first request is popped on the 2nd strobe's cycle, so 5 are accepted and 1 is dropped: ovf=1.
  - Results appear in order: head 0,1,2,3,4 with len 15,14,13,12,11.
  - Ptr 5 is never returned.
- Strobe in_ptr=0, assert rst on cycle 4 -> no out_vld, busy=0 and ovf=0 after reset; a subsequent in_ptr=13 returns len=2, tail=14.
- While walking from 10, write next[12]=NIL in the cycle that cur=11 -> walk ends at tail=12 with len=3 (write visible next cycle).

Source files
------------

// File: rtl/ll_walk_resp_if.sv
// Bundle for the linked-list walk responder: request strobes, table writes, result strobe.
// Defining LL_WALK_SUM_EN adds the out_sum result field.
interface ll_walk_resp_if #(
    parameter int unsigned PTR_W = 4
);
    logic [PTR_W-1:0]   in_ptr;
    logic               in_ptr_vld;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic [PTR_W-1:0]   wr_next;
    logic [PTR_W-1:0]   out_head;
    logic [PTR_W-1:0]   out_tail;
    logic [PTR_W-1:0]   out_len;
    logic               out_err;
    logic               out_vld;
    logic               busy;
    logic               ovf;
`ifdef LL_WALK_SUM_EN
    logic [2*PTR_W-1:0] out_sum;
`endif

    modport master (
        output in_ptr, in_ptr_vld, wr_en, wr_addr, wr_next,
        input
`ifdef LL_WALK_SUM_EN
              out_sum,
`endif
              out_head, out_tail, out_len, out_err, out_vld, busy, ovf
    );

    modport slave (
        input  in_ptr, in_ptr_vld, wr_en, wr_addr, wr_next,
        output
`ifdef LL_WALK_SUM_EN
               out_sum,
`endif
               out_head, out_tail, out_len, out_err, out_vld, busy, ovf
    );
endinterface

// File: rtl/ll_walk_resp.sv
// Linked-list walk responder: FIFOs head pointers, walks the next-pointer table to NIL.
// Optional LL_WALK_SUM_EN adds a per-walk sum of visited node indices (out_sum).
module ll_walk_resp #(
    parameter int unsigned PTR_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_HOPS   = (1 << PTR_W) - 1
) (
    input logic           clk,
    input logic           rst,
    ll_walk_resp_if.slave bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned NODES = 1 << PTR_W;
    localparam logic [PTR_W-1:0] NIL = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Entry NIL is held at NIL and never written, so it is never a valid hop.
    logic [PTR_W-1:0] tbl [NODES];
    logic [PTR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic             push, pop, empty, full;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, cur_q, cur_d, len_q, len_d, len_inc, nxt;
    logic [PTR_W-1:0] out_head_q, out_head_d, out_tail_q, out_tail_d, out_len_q, out_len_d;
    logic             out_err_q, out_err_d;
`ifdef LL_WALK_SUM_EN
    logic [2*PTR_W-1:0] sum_q, sum_d, out_sum_q, out_sum_d;
`endif

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign push    = bus.in_ptr_vld && (!full || pop);
    assign nxt     = tbl[cur_q];
    assign len_inc = len_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                tbl[i] <= (i >= NODES - 2) ? NIL : PTR_W'(i + 1);
            end
        end else if (bus.wr_en && bus.wr_addr != NIL) begin
            tbl[bus.wr_addr] <= bus.wr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.in_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
            if (bus.in_ptr_vld && !push) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        cur_d      = cur_q;
        len_d      = len_q;
        out_head_d = out_head_q;
        out_tail_d = out_tail_q;
        out_len_d  = out_len_q;
        out_err_d  = out_err_q;
`ifdef LL_WALK_SUM_EN
        sum_d      = sum_q;
        out_sum_d  = out_sum_q;
`endif
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    head_d = fifo_mem[rd_ptr_q];
                    cur_d  = fifo_mem[rd_ptr_q];
                    len_d  = '0;
`ifdef LL_WALK_SUM_EN
                    sum_d  = '0;
`endif
                    if (fifo_mem[rd_ptr_q] == NIL) begin
                        state_d    = DONE;
                        out_head_d = fifo_mem[rd_ptr_q];
                        out_tail_d = NIL;
                        out_len_d  = '0;
                        out_err_d  = 1'b0;
`ifdef LL_WALK_SUM_EN
                        out_sum_d  = '0;
`endif
                    end else begin
                        state_d = WALK;
                    end
                end
            end
            WALK: begin
                len_d = len_inc;
`ifdef LL_WALK_SUM_EN
                sum_d = sum_q + (2*PTR_W)'(cur_q);
`endif
                // NIL check wins over the hop limit: a full-length acyclic list is not an error.
                if (nxt == NIL || len_inc == PTR_W'(MAX_HOPS)) begin
                    state_d    = DONE;
                    out_head_d = head_q;
                    out_tail_d = cur_q;
                    out_len_d  = len_inc;
                    out_err_d  = (nxt != NIL);
`ifdef LL_WALK_SUM_EN
                    out_sum_d  = sum_d;
`endif
                end else begin
                    cur_d = nxt;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            cur_q      <= '0;
            len_q      <= '0;
            out_head_q <= '0;
            out_tail_q <= NIL;
            out_len_q  <= '0;
            out_err_q  <= 1'b0;
`ifdef LL_WALK_SUM_EN
            sum_q      <= '0;
            out_sum_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            cur_q      <= cur_d;
            len_q      <= len_d;
            out_head_q <= out_head_d;
            out_tail_q <= out_tail_d;
            out_len_q  <= out_len_d;
            out_err_q  <= out_err_d;
`ifdef LL_WALK_SUM_EN
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
`endif
        end
    end

    assign bus.out_head = out_head_q;
    assign bus.out_tail = out_tail_q;
    assign bus.out_len  = out_len_q;
    assign bus.out_err  = out_err_q;
    assign bus.out_vld  = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE) || !empty;
    assign bus.ovf      = ovf_q;
`ifdef LL_WALK_SUM_EN
    assign bus.out_sum  = out_sum_q;
`endif
endmodule
